// File: rtl/turbo_enc_sequencer_if.sv
// Bundles the start/abort handshake, the block-RAM read port and the encoder
// control lines that pass between the input buffer, the sequencer and the encoder.
interface turbo_enc_sequencer_if #(
  parameter int ADDR_W = 13
);
  logic              start;
  logic              k_sel;
  logic              abort;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_data;
  logic              enc_ck;
  logic              enc_data_ready;
  logic              enc_en;
  logic              enc_tail;
  logic              busy;
  logic              done;

  modport master (
    output start, k_sel, abort, rd_data,
    input  rd_en, rd_addr, enc_ck, enc_data_ready, enc_en, enc_tail, busy, done
  );

  modport slave (
    input  start, k_sel, abort, rd_data,
    output rd_en, rd_addr, enc_ck, enc_data_ready, enc_en, enc_tail, busy, done
  );
endinterface

// File: rtl/turbo_enc_sequencer.sv
// Walks one constituent encoder through a code block: prime the RAM read,
// stream K systematic bits, drive N_TAIL termination cycles, then pulse done.
module turbo_enc_sequencer #(
  parameter int K_SMALL = 1056,
  parameter int K_LARGE = 6144,
  parameter int ADDR_W  = 13,
  parameter int N_TAIL  = 3
) (
  input logic                  clk,
  input logic                  aclr,
  turbo_enc_sequencer_if.slave bus
);

  localparam int TAIL_W = (N_TAIL > 1) ? $clog2(N_TAIL) : 1;
  localparam logic [ADDR_W-1:0] K_SMALL_W = ADDR_W'(K_SMALL);
  localparam logic [ADDR_W-1:0] K_LARGE_W = ADDR_W'(K_LARGE);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);
  localparam logic [TAIL_W-1:0] TAIL_LAST = TAIL_W'(N_TAIL - 1);

  typedef enum logic [2:0] {IDLE, PRIME, DATA, TAIL, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] k_reg;
  logic [ADDR_W-1:0] bit_cnt;
  logic [TAIL_W-1:0] tail_cnt;
  logic              rd_en_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              ready_q;
  logic              en_q;
  logic              tail_q;
  logic              busy_q;
  logic              done_q;

  logic [ADDR_W-1:0] k_last;
  logic [ADDR_W-1:0] bit_nxt;

  assign k_last  = k_reg - ONE;
  assign bit_nxt = bit_cnt + ONE;

  // Outputs are loaded together with the state they belong to, so every
  // control line except enc_ck comes straight from a flop.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state     <= IDLE;
      k_reg     <= K_SMALL_W;
      bit_cnt   <= '0;
      tail_cnt  <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      ready_q   <= 1'b0;
      en_q      <= 1'b0;
      tail_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      if (bus.abort && state != IDLE) begin
        state     <= IDLE;
        bit_cnt   <= '0;
        tail_cnt  <= '0;
        rd_en_q   <= 1'b0;
        rd_addr_q <= '0;
        en_q      <= 1'b0;
        tail_q    <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start && !bus.abort) begin
              state     <= PRIME;
              k_reg     <= bus.k_sel ? K_LARGE_W : K_SMALL_W;
              rd_en_q   <= 1'b1;
              rd_addr_q <= '0;
              busy_q    <= 1'b1;
            end
          end
          PRIME: begin
            state     <= DATA;
            bit_cnt   <= '0;
            en_q      <= 1'b1;
            ready_q   <= 1'b1;
            rd_en_q   <= (k_last != '0);
            rd_addr_q <= (k_last != '0) ? ONE : rd_addr_q;
          end
          DATA: begin
            if (bit_cnt == k_last) begin
              state    <= TAIL;
              tail_cnt <= '0;
              tail_q   <= 1'b1;
              rd_en_q  <= 1'b0;
            end else begin
              bit_cnt <= bit_nxt;
              // The read issued now feeds bit_nxt+1; stop once the last address is out.
              if (bit_nxt != k_last) begin
                rd_en_q   <= 1'b1;
                rd_addr_q <= bit_nxt + ONE;
              end else begin
                rd_en_q <= 1'b0;
              end
            end
          end
          TAIL: begin
            if (tail_cnt == TAIL_LAST) begin
              state  <= DONE;
              en_q   <= 1'b0;
              tail_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              tail_cnt <= tail_cnt + TAIL_W'(1);
            end
          end
          DONE: begin
            state     <= IDLE;
            busy_q    <= 1'b0;
            rd_addr_q <= '0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.enc_ck         = (state == DATA) & bus.rd_data;
  assign bus.rd_en          = rd_en_q;
  assign bus.rd_addr        = rd_addr_q;
  assign bus.enc_data_ready = ready_q;
  assign bus.enc_en         = en_q;
  assign bus.enc_tail       = tail_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;

endmodule

// File: tb/tb_turbo_enc_sequencer.sv
// Directed bench for turbo_enc_sequencer: a 1-bit synchronous RAM model feeds the
// sequencer and each scenario task checks framing, data order and handshakes.
module tb_turbo_enc_sequencer;

  localparam int ADDR_W  = 13;
  localparam int K_SMALL = 16;
  localparam int K_LARGE = 6144;
  localparam int N_TAIL  = 3;

  logic clk = 1'b0;
  logic aclr;

  turbo_enc_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  turbo_enc_sequencer #(
    .K_SMALL(K_SMALL),
    .K_LARGE(K_LARGE),
    .ADDR_W (ADDR_W),
    .N_TAIL (N_TAIL)
  ) dut (
    .clk (clk),
    .aclr(aclr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  bit mem [0:(1<<ADDR_W)-1];

  // Synchronous read: data for the address presented in cycle n appears in cycle n+1.
  always @(posedge clk or posedge aclr) begin
    if (aclr) bus.rd_data <= 1'b0;
    else if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;

  // {busy, rd_en, enc_data_ready, enc_en, enc_tail, done, enc_ck}
  function automatic logic [6:0] outs();
    return {bus.busy, bus.rd_en, bus.enc_data_ready, bus.enc_en,
            bus.enc_tail, bus.done, bus.enc_ck};
  endfunction

  task automatic load_word(input logic [15:0] word);
    for (int i = 0; i < 16; i++) mem[i] = word[i];
  endtask

  task automatic do_start(input logic ksel);
    @(negedge clk);
    bus.start = 1'b1;
    bus.k_sel = ksel;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    aclr      = 1'b1;
    bus.start = 1'b0;
    bus.k_sel = 1'b0;
    bus.abort = 1'b0;
    @(negedge clk);
    n_checks++;
    if (outs() !== 7'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_outs: got %b expected %b", outs(), 7'b0);
    end
    n_checks++;
    if (bus.rd_addr !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_addr: got %0d expected 0", bus.rd_addr);
    end
    aclr = 1'b0;
  endtask

  task automatic test_small_block();
    logic [15:0] word;
    logic [6:0]  e;
    logic [ADDR_W-1:0] ea;
    word = 16'hA5C3;
    load_word(word);
    do_start(1'b0);
    for (int c = 1; c <= 22; c++) begin
      if (c > 1) @(negedge clk);
      if (c == 1)       e = 7'b1100000;
      else if (c <= 17) e = {1'b1, (c < 17), (c == 2), 1'b1, 1'b0, 1'b0, word[c-2]};
      else if (c <= 20) e = 7'b1001100;
      else if (c == 21) e = 7'b1000010;
      else              e = 7'b0000000;
      n_checks++;
      if (outs() !== e) begin
        n_fail++;
        $display("[TB] FAIL small_outs cycle %0d: got %b expected %b", c, outs(), e);
      end
      if (e[5]) begin
        ea = (c == 1) ? '0 : ADDR_W'(c - 1);
        n_checks++;
        if (bus.rd_addr !== ea) begin
          n_fail++;
          $display("[TB] FAIL small_addr cycle %0d: got %0d expected %0d", c, bus.rd_addr, ea);
        end
      end
    end
  endtask

  task automatic test_large_block();
    int c, exp_addr, bad_addr, bad_bit, done_c;
    for (int i = 0; i < K_LARGE; i++) mem[i] = bit'($urandom_range(0, 1));
    do_start(1'b1);
    c = 1; exp_addr = 0; bad_addr = 0; bad_bit = 0; done_c = 0;
    while (c < 7000) begin
      if (bus.rd_en) begin
        if (bus.rd_addr !== ADDR_W'(exp_addr)) bad_addr++;
        exp_addr++;
      end
      if (bus.enc_en && !bus.enc_tail) begin
        if (c < 2 || c - 2 >= K_LARGE) bad_bit++;
        else if (bus.enc_ck !== mem[c-2]) bad_bit++;
      end
      if (bus.done) begin
        done_c = c;
        break;
      end
      @(negedge clk);
      c++;
    end
    n_checks++;
    if (done_c != 6149) begin
      n_fail++;
      $display("[TB] FAIL large_done_cycle: got %0d expected 6149", done_c);
    end
    n_checks++;
    if (exp_addr != K_LARGE) begin
      n_fail++;
      $display("[TB] FAIL large_read_count: got %0d expected %0d", exp_addr, K_LARGE);
    end
    n_checks++;
    if (bad_addr != 0) begin
      n_fail++;
      $display("[TB] FAIL large_addr_seq: got %0d bad addresses expected 0", bad_addr);
    end
    n_checks++;
    if (bad_bit != 0) begin
      n_fail++;
      $display("[TB] FAIL large_data: got %0d bad bits expected 0", bad_bit);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int primes, done_c;
    load_word(16'hA5C3);
    @(negedge clk);
    bus.start = 1'b1;
    bus.k_sel = 1'b0;
    primes = 0; done_c = 0;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      if (bus.busy && bus.rd_en && !bus.enc_en) primes++;
      if (bus.done) done_c = c;
    end
    n_checks++;
    if (primes != 1) begin
      n_fail++;
      $display("[TB] FAIL b2b_prime_count: got %0d expected 1", primes);
    end
    n_checks++;
    if (done_c != 21) begin
      n_fail++;
      $display("[TB] FAIL b2b_done_cycle: got %0d expected 21", done_c);
    end
    n_checks++;
    if (outs() !== 7'b0) begin
      n_fail++;
      $display("[TB] FAIL b2b_idle_gap: got %b expected %b", outs(), 7'b0);
    end
    @(negedge clk);
    n_checks++;
    if (outs() !== 7'b1100000) begin
      n_fail++;
      $display("[TB] FAIL b2b_restart_prime: got %b expected %b", outs(), 7'b1100000);
    end
    bus.start = 1'b0;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    n_checks++;
    if (outs() !== 7'b0) begin
      n_fail++;
      $display("[TB] FAIL b2b_abort_prime: got %b expected %b", outs(), 7'b0);
    end
  endtask

  task automatic test_abort();
    logic [15:0] word;
    int seen, done_c, bad, c;
    word = 16'hA5C3;
    load_word(word);
    do_start(1'b0);
    repeat (6) @(negedge clk);
    n_checks++;
    if (bus.enc_ck !== word[5] || !bus.enc_en) begin
      n_fail++;
      $display("[TB] FAIL abort_bit5: got ck=%b en=%b expected ck=%b en=1", bus.enc_ck, bus.enc_en, word[5]);
    end
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    n_checks++;
    if (outs() !== 7'b0 || bus.rd_addr !== '0) begin
      n_fail++;
      $display("[TB] FAIL abort_outs: got %b addr %0d expected 0000000 addr 0", outs(), bus.rd_addr);
    end
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("[TB] FAIL abort_no_done: got %0d active cycles expected 0", seen);
    end
    do_start(1'b0);
    c = 1; done_c = 0; bad = 0;
    while (c < 40 && done_c == 0) begin
      if (bus.enc_en && !bus.enc_tail) begin
        if (c < 2 || c > 17) bad++;
        else if (bus.enc_ck !== word[c-2]) bad++;
      end
      if (bus.done) done_c = c;
      else begin
        @(negedge clk);
        c++;
      end
    end
    n_checks++;
    if (done_c != 21 || bad != 0) begin
      n_fail++;
      $display("[TB] FAIL abort_rerun: got done cycle %0d bad bits %0d expected 21 and 0", done_c, bad);
    end
  endtask

  task automatic test_aclr_tail();
    int seen;
    load_word(16'hA5C3);
    do_start(1'b0);
    repeat (18) @(negedge clk);
    n_checks++;
    if (outs() !== 7'b1001100) begin
      n_fail++;
      $display("[TB] FAIL aclr_in_tail: got %b expected %b", outs(), 7'b1001100);
    end
    #2 aclr = 1'b1;
    #1;
    n_checks++;
    if (outs() !== 7'b0 || bus.rd_addr !== '0) begin
      n_fail++;
      $display("[TB] FAIL aclr_immediate: got %b addr %0d expected 0000000 addr 0", outs(), bus.rd_addr);
    end
    aclr = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.busy || bus.done || bus.enc_en) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("[TB] FAIL aclr_idle_after: got %0d active cycles expected 0", seen);
    end
  endtask

  task automatic test_ksel_toggle();
    int c, done_c, seen;
    load_word(16'hA5C3);
    @(negedge clk);
    bus.start = 1'b1;
    bus.k_sel = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    c = 1; done_c = 0;
    while (c < 60 && done_c == 0) begin
      bus.k_sel = ~bus.k_sel;
      @(negedge clk);
      c++;
      if (bus.done) done_c = c;
    end
    bus.k_sel = 1'b0;
    n_checks++;
    if (done_c != 21) begin
      n_fail++;
      $display("[TB] FAIL ksel_toggle_len: got done cycle %0d expected 21", done_c);
    end
    @(negedge clk);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    seen = 0;
    repeat (4) begin
      if (outs() !== 7'b0) seen++;
      @(negedge clk);
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("[TB] FAIL idle_abort_start: got %0d active cycles expected 0", seen);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_small_block();
    test_large_block();
    test_back_to_back();
    test_abort();
    test_aclr_tail();
    test_ksel_toggle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
